// File: rtl/xsync_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port RAM, standard or first-word-fall-through read.
// Latency: standard read data READ_LAT+1 edges after acceptance; FWFT head appears 1+READ_LAT edges after the write.
// Backpressure: writes refused while full (overflow pulse), reads refused while empty (underflow pulse).
module xsync_fifo #(
  parameter int    DATA_WIDTH        = 64,
  parameter int    FIFO_DEPTH        = 1024,
  parameter string RAM_PERFORMANCE   = "LOW_LATENCY",
  parameter int    FWFT_EN           = 0,
  parameter int    PROG_FULL_THRESH  = FIFO_DEPTH - 4,
  parameter int    PROG_EMPTY_THRESH = 4,
  localparam int   AW                = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  prog_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  prog_empty,
  output logic                  underflow,
  output logic [AW:0]           data_count
);

  localparam int READ_LAT = (RAM_PERFORMANCE == "HIGH_PERFORMANCE") ? 2 : 1;
  localparam int PF_DEPTH = READ_LAT + 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           cnt, cnt_nxt;
  logic                  wr_acc, rd_acc, ram_rd;
  logic [DATA_WIDTH-1:0] ram_q, pipe_dat;
  logic                  ram_q_vld, pipe_vld;

  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && !empty;
  assign data_count = cnt;

  // Occupancy after this edge; a simultaneous read and write leave it unchanged
  always_comb begin
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // Count, level flags and error pulses, all registered from the next count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      full       <= (cnt_nxt == FIFO_DEPTH[AW:0]);
      prog_full  <= (int'(cnt_nxt) >= PROG_FULL_THRESH);
      prog_empty <= (int'(cnt_nxt) <= PROG_EMPTY_THRESH);
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH; the read pointer follows RAM reads, not acknowledges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // RAM registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q     <= '0;
      ram_q_vld <= 1'b0;
    end else begin
      ram_q_vld <= ram_rd;
      if (ram_rd) ram_q <= mem[rd_ptr];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_hp
      logic [DATA_WIDTH-1:0] ram_q2;
      logic                  ram_q2_vld;
      // Extra RAM output register for timing
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ram_q2     <= '0;
          ram_q2_vld <= 1'b0;
        end else begin
          ram_q2     <= ram_q;
          ram_q2_vld <= ram_q_vld;
        end
      end
      assign pipe_dat = ram_q2;
      assign pipe_vld = ram_q2_vld;
    end else begin : g_ll
      assign pipe_dat = ram_q;
      assign pipe_vld = ram_q_vld;
    end
  endgenerate

  generate
    if (FWFT_EN != 0) begin : g_fwft
      logic [AW:0]           ram_cnt;
      logic [1:0]            pf_cnt, infl, pf_wr_idx;
      logic [2:0]            pf_occ;
      logic [DATA_WIDTH-1:0] pf_dat [4];

      // Keep fetching while buffered plus in-flight words (after this edge's pop) leave room
      assign pf_occ    = {1'b0, pf_cnt} + {1'b0, infl} - {2'b00, rd_acc};
      assign ram_rd    = (ram_cnt != '0) && (pf_occ < 3'(PF_DEPTH));
      assign pf_wr_idx = pf_cnt - {1'b0, rd_acc};
      assign valid     = (pf_cnt != 2'd0);
      assign empty     = !valid;
      assign dout      = pf_dat[0];

      // Words still resident in RAM (not yet fetched)
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ram_cnt <= '0;
        end else begin
          case ({wr_acc, ram_rd})
            2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
            2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
            default: ram_cnt <= ram_cnt;
          endcase
        end
      end

      // In-flight read count and prefetch buffer occupancy
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          infl   <= 2'd0;
          pf_cnt <= 2'd0;
        end else begin
          case ({ram_rd, pipe_vld})
            2'b10:   infl <= infl + 2'd1;
            2'b01:   infl <= infl - 2'd1;
            default: infl <= infl;
          endcase
          case ({pipe_vld, rd_acc})
            2'b10:   pf_cnt <= pf_cnt + 2'd1;
            2'b01:   pf_cnt <= pf_cnt - 2'd1;
            default: pf_cnt <= pf_cnt;
          endcase
        end
      end

      // Prefetch buffer: shift on acknowledge, arriving word lands behind the survivors
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 4; i++) pf_dat[i] <= '0;
        end else begin
          if (rd_acc) begin
            for (int i = 0; i < 3; i++) pf_dat[i] <= pf_dat[i+1];
          end
          if (pipe_vld) pf_dat[pf_wr_idx] <= pipe_dat;
        end
      end
    end else begin : g_std
      logic cnt_zero;

      assign ram_rd = rd_acc;
      assign empty  = cnt_zero;

      // Empty flag registered from the next count
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_zero <= 1'b1;
        else     cnt_zero <= (cnt_nxt == '0);
      end

      // Output register: one-cycle valid, data held between reads
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout  <= '0;
          valid <= 1'b0;
        end else begin
          valid <= pipe_vld;
          if (pipe_vld) dout <= pipe_dat;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_xsync_fifo.sv
// Directed bench for xsync_fifo: standard/LOW_LATENCY and FWFT/HIGH_PERFORMANCE instances, depth 16.
// Covers reset, ordering, full/overflow, underflow, thresholds, wrap streaming and async reset.
module tb_xsync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_wr = 1'b0, s_rd = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [DW-1:0] s_din = '0, f_din = '0;
  logic          s_full, s_prog_full, s_overflow, s_valid, s_empty, s_prog_empty, s_underflow;
  logic          f_full, f_prog_full, f_overflow, f_valid, f_empty, f_prog_empty, f_underflow;
  logic [DW-1:0] s_dout, f_dout;
  logic [4:0]    s_count, f_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_v;
  int n_out;

  always #5 clk = ~clk;

  xsync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RAM_PERFORMANCE("LOW_LATENCY"), .FWFT_EN(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .din(s_din), .full(s_full), .prog_full(s_prog_full),
    .overflow(s_overflow), .rd_en(s_rd), .dout(s_dout), .valid(s_valid), .empty(s_empty),
    .prog_empty(s_prog_empty), .underflow(s_underflow), .data_count(s_count));

  xsync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .FWFT_EN(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr), .din(f_din), .full(f_full), .prog_full(f_prog_full),
    .overflow(f_overflow), .rd_en(f_rd), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .prog_empty(f_prog_empty), .underflow(f_underflow), .data_count(f_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_full", s_full, 0);
    chk("rst_s_count", s_count, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_dout", s_dout, 0);
    chk("rst_s_pempty", s_prog_empty, 1);
    chk("rst_s_pfull", s_prog_full, 0);
    chk("rst_s_ovf", s_overflow, 0);
    chk("rst_s_udf", s_underflow, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_dout", f_dout, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Standard mode: write 1..4 then read 4
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_din = 8'(i + 1); tick();
    end
    s_wr = 1'b0;
    chk("t1_count4", s_count, 4);
    chk("t1_empty0", s_empty, 0);
    chk("t1_pempty_at4", s_prog_empty, 1);
    for (int i = 0; i < 6; i++) begin
      s_rd = (i < 4); tick();
      chk("t1_valid", s_valid, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk("t1_dout", s_dout, i);
      chk("t1_count", s_count, (i < 4) ? 3 - i : 0);
    end
    s_rd = 1'b0;
    chk("t1_empty_end", s_empty, 1);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h10 + i); tick();
      chk("fill_pfull", s_prog_full, (i + 1 >= 12));
    end
    chk("fill_full", s_full, 1);
    chk("fill_count", s_count, 16);
    s_din = 8'hEE; tick();
    chk("ovf_pulse", s_overflow, 1);
    chk("ovf_count", s_count, 16);
    s_wr = 1'b0; tick();
    chk("ovf_clear", s_overflow, 0);
    for (int i = 0; i < 17; i++) begin
      s_rd = (i < 16); tick();
      if (i == 0) chk("drain_full0", s_full, 0);
      if (i >= 1) begin
        chk("drain_valid", s_valid, 1);
        chk("drain_dout", s_dout, 8'h10 + i - 1);
      end
    end
    s_rd = 1'b0; tick();
    chk("drain_valid_end", s_valid, 0);
    chk("drain_empty", s_empty, 1);

    // Read and write together while empty
    s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h55; tick();
    chk("udf_pulse", s_underflow, 1);
    chk("udf_count", s_count, 1);
    chk("udf_empty", s_empty, 0);
    s_wr = 1'b0; s_rd = 1'b0; tick();
    chk("udf_clear", s_underflow, 0);
    s_rd = 1'b1; tick(); s_rd = 1'b0; tick();
    chk("udf_word_vld", s_valid, 1);
    chk("udf_word", s_dout, 8'h55);
    tick();
    chk("udf_count0", s_count, 0);

    // FWFT HIGH_PERFORMANCE: single write of 0xA5
    f_wr = 1'b1; f_din = 8'hA5; tick();
    f_wr = 1'b0;
    chk("fw_n0_valid", f_valid, 0);
    tick(); chk("fw_n1_valid", f_valid, 0);
    tick(); chk("fw_n2_valid", f_valid, 0);
    chk("fw_n2_empty", f_empty, 1);
    tick();
    chk("fw_n3_valid", f_valid, 1);
    chk("fw_n3_dout", f_dout, 8'hA5);
    chk("fw_n3_empty", f_empty, 0);
    chk("fw_count1", f_count, 1);
    tick(); tick();
    chk("fw_hold_valid", f_valid, 1);
    chk("fw_hold_dout", f_dout, 8'hA5);
    f_rd = 1'b1; tick(); f_rd = 1'b0;
    chk("fw_ack_valid", f_valid, 0);
    chk("fw_ack_empty", f_empty, 1);
    chk("fw_ack_count", f_count, 0);

    // FWFT read and write together while empty
    f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h3C; tick();
    f_wr = 1'b0; f_rd = 1'b0;
    chk("fw_udf_pulse", f_underflow, 1);
    chk("fw_udf_count", f_count, 1);
    tick(); tick(); tick();
    chk("fw_udf_valid", f_valid, 1);
    chk("fw_udf_dout", f_dout, 8'h3C);
    f_rd = 1'b1; tick(); f_rd = 1'b0;
    chk("fw_udf_count0", f_count, 0);

    // Standard mode: hold 8 words, stream 100 cycles through the wrap
    for (int i = 0; i < 8; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h40 + i); tick();
    end
    exp_v = 8'h40;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      s_wr = 1'b1; s_rd = 1'b1; s_din = 8'(8'h48 + i); tick();
      chk("s_wrap_count", s_count, 8);
      if (s_valid) begin
        chk("s_wrap_dout", s_dout, exp_v);
        exp_v++; n_out++;
      end
    end
    s_wr = 1'b0; s_rd = 1'b0; tick();
    if (s_valid) begin
      chk("s_wrap_dout", s_dout, exp_v);
      exp_v++; n_out++;
    end
    chk("s_wrap_nout", n_out, 100);

    // FWFT mode: hold 8 words, zero-bubble stream 100 cycles
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1; f_din = 8'(8'h80 + i); tick();
    end
    f_wr = 1'b0;
    tick(); tick(); tick(); tick();
    chk("f_wrap_count0", f_count, 8);
    exp_v = 8'h80;
    for (int i = 0; i < 100; i++) begin
      chk("f_wrap_valid", f_valid, 1);
      chk("f_wrap_dout", f_dout, exp_v);
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'(8'h88 + i); tick();
      exp_v++;
      chk("f_wrap_count", f_count, 8);
    end
    f_wr = 1'b0; f_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("f_tail_dout", f_dout, exp_v);
      f_rd = 1'b1; tick(); exp_v++;
    end
    f_rd = 1'b0;
    chk("f_count5", f_count, 5);

    // Standard: drain 3 so 5 remain with a read still in flight
    s_rd = 1'b1; tick(); tick(); tick(); s_rd = 1'b0;
    chk("s_count5", s_count, 5);
    chk("s_pempty_at5", s_prog_empty, 0);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_s_count", s_count, 0);
    chk("ar_s_empty", s_empty, 1);
    chk("ar_s_valid", s_valid, 0);
    chk("ar_s_dout", s_dout, 0);
    chk("ar_s_pempty", s_prog_empty, 1);
    chk("ar_f_count", f_count, 0);
    chk("ar_f_valid", f_valid, 0);
    chk("ar_f_empty", f_empty, 1);
    chk("ar_f_dout", f_dout, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_s_valid", s_valid, 0);
      chk("post_f_valid", f_valid, 0);
      chk("post_s_count", s_count, 0);
    end
    s_wr = 1'b1; s_din = 8'h77; f_wr = 1'b1; f_din = 8'h78; tick();
    s_wr = 1'b0; f_wr = 1'b0; s_rd = 1'b1; tick();
    s_rd = 1'b0; tick();
    chk("post_s_new_vld", s_valid, 1);
    chk("post_s_new_dout", s_dout, 8'h77);
    tick();
    chk("post_f_new_vld", f_valid, 1);
    chk("post_f_new_dout", f_dout, 8'h78);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
